// File: rtl/misr_seq.sv
// misr_seq: sequencer for the RAMDAC signature (MISR/CRC) capture path.
// Accepts a host request for N frames, drives misr_cntl to the blank
// generator, follows the init_crc / misr_done handshake frame by frame,
// latches each frame signature and tracks whether all signatures matched.
// Single clock domain (pixclk); host inputs arrive already synchronised.
//
// Ports:
//   pixclk       pixel clock
//   reset        asynchronous, active-low reset
//   start        single-cycle capture request (ignored while busy)
//   abort        single-cycle cancel (wins over start and timeout)
//   num_frames   frames to capture, 0 = 2**FRM_W; sampled on accepted start
//   vsync        frame marker (timeout build only)
//   init_crc     one-cycle MISR init pulse
//   misr_done    level, rises when a frame signature is complete
//   misr_sig     current MISR signature
//   misr_cntl    capture enable to blank generator
//   busy         sequence in progress (ARM/RUN)
//   done         sticky completion flag
//   err          sticky timeout flag (0 unless MISR_SEQ_TIMEOUT_EN)
//   frames_left  frames remaining
//   sig_out      signature of most recent completed frame
//   sig_valid    one-cycle pulse when sig_out updates
//   sig_stable   all frames captured so far had equal signatures
//
// Optional feature: define MISR_SEQ_TIMEOUT_EN to enable the vsync-based
// timeout (TO_FRAMES vsync rises without progress -> ERR).

module misr_seq #(
  parameter int SIG_W     = 24,
  parameter int FRM_W     = 4,
  parameter int TO_FRAMES = 4
) (
  input  logic             pixclk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [FRM_W-1:0] num_frames,
  input  logic             vsync,
  input  logic             init_crc,
  input  logic             misr_done,
  input  logic [SIG_W-1:0] misr_sig,
  output logic             misr_cntl,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [FRM_W:0]   frames_left,
  output logic [SIG_W-1:0] sig_out,
  output logic             sig_valid,
  output logic             sig_stable
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_DONE
`ifdef MISR_SEQ_TIMEOUT_EN
    , S_ERR
`endif
  } state_t;

  localparam logic [FRM_W:0] LOAD_MAX = {1'b1, {FRM_W{1'b0}}};
  localparam logic [FRM_W:0] ONE      = {{FRM_W{1'b0}}, 1'b1};

  state_t r_state;
  logic   r_misr_done_d;
  logic   r_first;
  logic   w_rise;

  assign w_rise = misr_done & ~r_misr_done_d;

`ifdef MISR_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TO_FRAMES + 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            r_vsync_d;
  logic            w_vs_rise;
  logic            w_active;
  logic            w_progress;
  logic            w_timeout;

  assign w_vs_rise  = vsync & ~r_vsync_d;
  assign w_active   = (r_state == S_ARM) || (r_state == S_RUN);
  assign w_progress = ((r_state == S_ARM) && init_crc) ||
                      ((r_state == S_RUN) && w_rise);
  // The rise that would make the count reach TO_FRAMES triggers the timeout.
  assign w_timeout  = w_active && w_vs_rise &&
                      (r_to_cnt == TO_W'(TO_FRAMES - 1));

  always_ff @(posedge pixclk or negedge reset) begin
    if (!reset) begin
      r_to_cnt  <= '0;
      r_vsync_d <= 1'b0;
    end else begin
      r_vsync_d <= vsync;
      if (abort || w_timeout || !w_active || w_progress)
        r_to_cnt <= '0;
      else if (w_vs_rise)
        r_to_cnt <= r_to_cnt + 1'b1;
    end
  end
`else
  logic w_unused;
  assign w_unused = vsync ^ (TO_FRAMES == 0);
  assign err      = 1'b0;
`endif

  always_ff @(posedge pixclk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_misr_done_d <= 1'b0;
      r_first       <= 1'b0;
      misr_cntl     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
`ifdef MISR_SEQ_TIMEOUT_EN
      err           <= 1'b0;
`endif
      frames_left   <= '0;
      sig_out       <= '0;
      sig_valid     <= 1'b0;
      sig_stable    <= 1'b1;
    end else begin
      r_misr_done_d <= misr_done;
      sig_valid     <= 1'b0;
      if (abort) begin
        r_state     <= S_IDLE;
        misr_cntl   <= 1'b0;
        busy        <= 1'b0;
        frames_left <= '0;
      end
`ifdef MISR_SEQ_TIMEOUT_EN
      else if (w_timeout) begin
        r_state   <= S_ERR;
        misr_cntl <= 1'b0;
        busy      <= 1'b0;
        err       <= 1'b1;
      end
`endif
      else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              frames_left <= (num_frames == '0) ? LOAD_MAX : {1'b0, num_frames};
              done        <= 1'b0;
`ifdef MISR_SEQ_TIMEOUT_EN
              err         <= 1'b0;
`endif
              sig_stable  <= 1'b1;
              r_first     <= 1'b1;
              misr_cntl   <= 1'b1;
              busy        <= 1'b1;
              r_state     <= S_ARM;
            end
          end
          S_ARM: begin
            if (init_crc)
              r_state <= S_RUN;
          end
          S_RUN: begin
            if (w_rise) begin
              sig_out   <= misr_sig;
              sig_valid <= 1'b1;
              r_first   <= 1'b0;
              if (!r_first && (misr_sig != sig_out))
                sig_stable <= 1'b0;
              if (frames_left != '0)
                frames_left <= frames_left - ONE;
              // Completion outputs are set on entry to DONE so busy and
              // misr_cntl are already low while DONE is occupied.
              if (frames_left == ONE) begin
                r_state   <= S_DONE;
                misr_cntl <= 1'b0;
                busy      <= 1'b0;
                done      <= 1'b1;
              end else begin
                r_state <= S_ARM;
              end
            end
          end
          S_DONE:  r_state <= S_IDLE;
`ifdef MISR_SEQ_TIMEOUT_EN
          S_ERR:   r_state <= S_IDLE;
`endif
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_misr_seq.sv
module tb_misr_seq;

  localparam int SIG_W = 24;
  localparam int FRM_W = 4;

  logic             pixclk = 1'b0;
  logic             reset;
  logic             start;
  logic             abort;
  logic [FRM_W-1:0] num_frames;
  logic             vsync;
  logic             init_crc;
  logic             misr_done;
  logic [SIG_W-1:0] misr_sig;
  logic             misr_cntl;
  logic             busy;
  logic             done;
  logic             err;
  logic [FRM_W:0]   frames_left;
  logic [SIG_W-1:0] sig_out;
  logic             sig_valid;
  logic             sig_stable;

  misr_seq #(.SIG_W(SIG_W), .FRM_W(FRM_W), .TO_FRAMES(4)) dut (
    .pixclk(pixclk), .reset(reset), .start(start), .abort(abort),
    .num_frames(num_frames), .vsync(vsync), .init_crc(init_crc),
    .misr_done(misr_done), .misr_sig(misr_sig), .misr_cntl(misr_cntl),
    .busy(busy), .done(done), .err(err), .frames_left(frames_left),
    .sig_out(sig_out), .sig_valid(sig_valid), .sig_stable(sig_stable)
  );

  always #5 pixclk = ~pixclk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_valid  = 0;
  logic [SIG_W-1:0] exp_q[$];

  typedef struct {
    logic [FRM_W-1:0] nf;
    logic [SIG_W-1:0] sig_a;   // signature of all frames but the last
    logic [SIG_W-1:0] sig_b;   // signature of the last frame
    int               load;
    logic             stable;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge pixclk);
    #1;
  endtask

  // Scoreboard: every sig_valid pulse must match the oldest expected signature.
  always @(negedge pixclk) begin
    if (reset === 1'b1 && sig_valid === 1'b1) begin
      n_valid++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL stray_sig_valid: got sig_out %0h expected no pulse (t=%0t)", sig_out, $time);
      end else begin
        logic [SIG_W-1:0] e;
        e = exp_q.pop_front();
        if (sig_out !== e) begin
          n_fail++;
          $display("FAIL sig_out_sb: got %0h expected %0h (t=%0t)", sig_out, e, $time);
        end
      end
    end
  end

  // One blank-generator frame: init_crc pulse, then misr_done rise with sig.
  task automatic frame(input logic [SIG_W-1:0] sig, input int exp_left);
    tick();
    init_crc = 1'b1;
    tick();
    init_crc  = 1'b0;
    misr_sig  = sig;
    misr_done = 1'b1;
    exp_q.push_back(sig);
    tick();
    chk("frames_left_dec", 32'(frames_left), 32'(exp_left));
    misr_done = 1'b0;
    tick();
  endtask

  task automatic do_start(input logic [FRM_W-1:0] nf);
    start      = 1'b1;
    num_frames = nf;
    tick();
    start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int v0;
    v0 = n_valid;
    do_start(v.nf);
    chk("load_frames_left", 32'(frames_left), 32'(v.load));
    chk("start_misr_cntl", 32'(misr_cntl), 32'd1);
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_done_clr", 32'(done), 32'd0);
    for (int k = 0; k < v.load; k++) begin
      frame((k == v.load - 1) ? v.sig_b : v.sig_a, v.load - k - 1);
      if (k < v.load - 1) chk("mid_misr_cntl", 32'(misr_cntl), 32'd1);
    end
    chk("end_done", 32'(done), 32'd1);
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_misr_cntl", 32'(misr_cntl), 32'd0);
    chk("end_sig_stable", 32'(sig_stable), 32'(v.stable));
    chk("end_sig_out", 32'(sig_out), 32'(v.sig_b));
    chk("valid_count", 32'(n_valid - v0), 32'(v.load));
    tick();
    tick();
    chk("done_sticky", 32'(done), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{4'd3,  24'hA5A5A5, 24'hA5A5A5, 3,  1'b1};
    tbl[1] = '{4'd2,  24'h123456, 24'h123457, 2,  1'b0};
    tbl[2] = '{4'd0,  24'h0F0F0F, 24'h0F0F0F, 16, 1'b1};
    tbl[3] = '{4'd1,  24'h111111, 24'h222222, 1,  1'b1};
    tbl[4] = '{4'd15, 24'hC0FFEE, 24'hC0FFEF, 15, 1'b0};

    reset = 1'b0; start = 1'b0; abort = 1'b0; num_frames = '0;
    vsync = 1'b0; init_crc = 1'b0; misr_done = 1'b0; misr_sig = '0;
    tick();
    tick();
    chk("rst_misr_cntl", 32'(misr_cntl), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_frames_left", 32'(frames_left), 32'd0);
    chk("rst_sig_out", 32'(sig_out), 32'd0);
    chk("rst_sig_valid", 32'(sig_valid), 32'd0);
    chk("rst_sig_stable", 32'(sig_stable), 32'd1);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) begin
      run_vec(tbl[i]);
    end

    // Abort in RUN after one frame.
    do_start(4'd3);
    frame(24'hABCDEF, 2);
    tick();
    init_crc = 1'b1;
    tick();
    init_crc = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_misr_cntl", 32'(misr_cntl), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_frames_left", 32'(frames_left), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sig_out", 32'(sig_out), 32'hABCDEF);

    // start and abort together: start dropped, never leaves IDLE.
    start = 1'b1; abort = 1'b1; num_frames = 4'd5;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("sa_busy", 32'(busy), 32'd0);
    chk("sa_misr_cntl", 32'(misr_cntl), 32'd0);
    chk("sa_frames_left", 32'(frames_left), 32'd0);
    tick(); tick(); tick();
    chk("sa_busy_later", 32'(busy), 32'd0);
    chk("sa_done", 32'(done), 32'd0);
    chk("sa_sig_out", 32'(sig_out), 32'hABCDEF);

    // start while busy, stale misr_done in ARM, init_crc in RUN.
    do_start(4'd4);
    frame(24'h0000AA, 3);
    start = 1'b1; num_frames = 4'd9;
    tick();
    start = 1'b0;
    chk("busy_start_frames_left", 32'(frames_left), 32'd3);
    misr_done = 1'b1;
    tick(); tick();
    misr_done = 1'b0;
    tick();
    chk("stale_frames_left", 32'(frames_left), 32'd3);
    init_crc = 1'b1;
    tick();
    init_crc = 1'b0;
    tick();
    init_crc = 1'b1;
    tick();
    init_crc = 1'b0;
    chk("run_initcrc_frames_left", 32'(frames_left), 32'd3);
    chk("run_initcrc_misr_cntl", 32'(misr_cntl), 32'd1);
    frame(24'h0000AA, 2);
    frame(24'h0000AA, 1);
    frame(24'h0000AA, 0);
    chk("busy_seq_done", 32'(done), 32'd1);
    chk("busy_seq_stable", 32'(sig_stable), 32'd1);

    // Timeout: init_crc withheld for 4 vsync rises.
    do_start(4'd2);
    for (int i = 0; i < 4; i++) begin
      vsync = 1'b1;
      tick();
      vsync = 1'b0;
      if (i == 3) begin
`ifdef MISR_SEQ_TIMEOUT_EN
        chk("to_err", 32'(err), 32'd1);
        chk("to_busy", 32'(busy), 32'd0);
        chk("to_misr_cntl", 32'(misr_cntl), 32'd0);
`else
        chk("noto_err", 32'(err), 32'd0);
        chk("noto_busy", 32'(busy), 32'd1);
        chk("noto_misr_cntl", 32'(misr_cntl), 32'd1);
`endif
      end
      tick();
    end
`ifdef MISR_SEQ_TIMEOUT_EN
    chk("to_err_sticky", 32'(err), 32'd1);
`else
    chk("noto_busy_later", 32'(busy), 32'd1);
`endif
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();

    // Asynchronous reset mid-sequence.
    do_start(4'd2);
    chk("restart_err_clr", 32'(err), 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_misr_cntl", 32'(misr_cntl), 32'd0);
    chk("mrst_frames_left", 32'(frames_left), 32'd0);
    chk("mrst_sig_out", 32'(sig_out), 32'd0);
    chk("mrst_sig_stable", 32'(sig_stable), 32'd1);
    tick();
    reset = 1'b1;
    tick();
    tick();

    chk("sb_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
